// File: rtl/croc_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : croc_bank_arbiter
// Purpose  : Round-robin OBI arbiter in front of one single-port SRAM bank,
//            with range checking and one-cycle response routing.
// Revision : 1.0 - initial release
// ============================================================================
module croc_bank_arbiter #(
    parameter int          NumMgr       = 4,
    parameter int          BankNumWords = 512,
    parameter logic [31:0] BaseAddr     = 32'h1000_0000,
    parameter int          IdWidth      = 3,
    parameter int          AW           = $clog2(BankNumWords)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NumMgr-1:0]         req_i,
    output logic [NumMgr-1:0]         gnt_o,
    input  logic [NumMgr*32-1:0]      addr_i,
    input  logic [NumMgr-1:0]         we_i,
    input  logic [NumMgr*4-1:0]       be_i,
    input  logic [NumMgr*32-1:0]      wdata_i,
    input  logic [NumMgr*IdWidth-1:0] aid_i,
    output logic [NumMgr-1:0]         rvalid_o,
    output logic [NumMgr*32-1:0]      rdata_o,
    output logic [NumMgr*IdWidth-1:0] rid_o,
    output logic [NumMgr-1:0]         err_o,
    output logic                      sram_req_o,
    output logic                      sram_we_o,
    output logic [AW-1:0]             sram_addr_o,
    output logic [3:0]                sram_be_o,
    output logic [31:0]               sram_wdata_o,
    input  logic [31:0]               sram_rdata_i
);

    localparam int               c_PTR_W      = (NumMgr > 1) ? $clog2(NumMgr) : 1;
    localparam logic [c_PTR_W:0] c_NUM        = (c_PTR_W+1)'(NumMgr);
    localparam logic [31:0]      c_BANK_BYTES = 32'(BankNumWords * 4);

    logic [c_PTR_W-1:0] r_rr;
    logic               r_rsp_valid;
    logic [c_PTR_W-1:0] r_rsp_idx;
    logic [IdWidth-1:0] r_rsp_id;
    logic               r_rsp_err;

    logic [NumMgr-1:0]  w_gnt;
    logic               w_gnt_any;
    logic [c_PTR_W-1:0] w_winner;
    logic [c_PTR_W:0]   w_sum;
    logic [31:0]        w_addr;
    logic               w_we;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata;
    logic [IdWidth-1:0] w_aid;
    logic [31:0]        w_off;
    logic               w_in_range;
    logic               w_sram_fire;

    // Scan requesters starting at the round-robin pointer; first hit wins.
    always_comb begin
        w_gnt     = '0;
        w_gnt_any = 1'b0;
        w_winner  = '0;
        w_sum     = '0;
        for (int i = 0; i < NumMgr; i++) begin
            w_sum = {1'b0, r_rr} + (c_PTR_W+1)'(i);
            if (w_sum >= c_NUM) begin
                w_sum = w_sum - c_NUM;
            end
            if (!w_gnt_any && req_i[w_sum[c_PTR_W-1:0]]) begin
                w_gnt_any                   = 1'b1;
                w_winner                    = w_sum[c_PTR_W-1:0];
                w_gnt[w_sum[c_PTR_W-1:0]]   = 1'b1;
            end
        end
    end

    always_comb begin
        w_addr  = '0;
        w_we    = 1'b0;
        w_be    = '0;
        w_wdata = '0;
        w_aid   = '0;
        for (int p = 0; p < NumMgr; p++) begin
            if (w_winner == c_PTR_W'(p)) begin
                w_addr  = addr_i[p*32 +: 32];
                w_we    = we_i[p];
                w_be    = be_i[p*4 +: 4];
                w_wdata = wdata_i[p*32 +: 32];
                w_aid   = aid_i[p*IdWidth +: IdWidth];
            end
        end
    end

    // Unsigned difference makes addresses below the base wrap to huge offsets.
    assign w_off       = w_addr - BaseAddr;
    assign w_in_range  = (w_off < c_BANK_BYTES);
    assign w_sram_fire = w_gnt_any && w_in_range && !rst_i;

    assign gnt_o        = rst_i ? '0 : w_gnt;
    assign sram_req_o   = w_sram_fire;
    assign sram_we_o    = w_sram_fire ? w_we       : 1'b0;
    assign sram_addr_o  = w_sram_fire ? w_off[AW+1:2] : '0;
    assign sram_be_o    = w_sram_fire ? w_be       : 4'b0;
    assign sram_wdata_o = w_sram_fire ? w_wdata    : 32'b0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rr        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_idx   <= '0;
            r_rsp_id    <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= w_gnt_any;
            if (w_gnt_any) begin
                r_rr      <= (w_winner == c_PTR_W'(NumMgr-1)) ? '0 : w_winner + 1'b1;
                r_rsp_idx <= w_winner;
                r_rsp_id  <= w_aid;
                r_rsp_err <= !w_in_range;
            end
        end
    end

    always_comb begin
        rvalid_o = '0;
        rdata_o  = '0;
        rid_o    = '0;
        err_o    = '0;
        for (int p = 0; p < NumMgr; p++) begin
            if (r_rsp_valid && !rst_i && (r_rsp_idx == c_PTR_W'(p))) begin
                rvalid_o[p]                   = 1'b1;
                rdata_o[p*32 +: 32]           = r_rsp_err ? 32'b0 : sram_rdata_i;
                rid_o[p*IdWidth +: IdWidth]   = r_rsp_id;
                err_o[p]                      = r_rsp_err;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_croc_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_croc_bank_arbiter
// Purpose  : Directed self-checking bench for croc_bank_arbiter with an SRAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_croc_bank_arbiter;

    localparam int          N    = 4;
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N-1:0]    gnt;
    logic [N*32-1:0] addr;
    logic [N-1:0]    we;
    logic [N*4-1:0]  be;
    logic [N*32-1:0] wdata;
    logic [N*3-1:0]  aid;
    logic [N-1:0]    rvalid;
    logic [N*32-1:0] rdata;
    logic [N*3-1:0]  rid;
    logic [N-1:0]    err;
    logic            sram_req;
    logic            sram_we;
    logic [8:0]      sram_addr;
    logic [3:0]      sram_be;
    logic [31:0]     sram_wdata;
    logic [31:0]     sram_rdata;

    logic [31:0] mem [0:511];
    logic        bd_we;
    logic [8:0]  bd_addr;
    logic [31:0] bd_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    croc_bank_arbiter #(
        .NumMgr(N), .BankNumWords(512), .BaseAddr(BASE), .IdWidth(3)
    ) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .addr_i(addr),
        .we_i(we), .be_i(be), .wdata_i(wdata), .aid_i(aid), .rvalid_o(rvalid),
        .rdata_o(rdata), .rid_o(rid), .err_o(err), .sram_req_o(sram_req),
        .sram_we_o(sram_we), .sram_addr_o(sram_addr), .sram_be_o(sram_be),
        .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata)
    );

    // Single-port macro model: one-cycle read latency, byte-masked writes.
    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (sram_req) begin
            if (sram_we) begin
                for (int b = 0; b < 4; b++)
                    if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [8:0] a, input logic [31:0] d);
        bd_addr = a;
        bd_data = d;
        bd_we   = 1'b1;
        tick();
        bd_we   = 1'b0;
    endtask

    task automatic drive(input int p, input logic [31:0] a, input logic w,
                         input logic [3:0] b, input logic [31:0] d, input logic [2:0] id);
        req[p]           = 1'b1;
        addr[p*32 +: 32] = a;
        we[p]            = w;
        be[p*4 +: 4]     = b;
        wdata[p*32 +: 32] = d;
        aid[p*3 +: 3]    = id;
    endtask

    initial begin
        int pp;
        rst   = 1'b1;
        req   = '0;
        addr  = '0;
        we    = '0;
        be    = '0;
        wdata = '0;
        aid   = '0;
        bd_we = 1'b0;
        bd_addr = '0;
        bd_data = '0;

        // Reset: outputs forced low even with requests present
        for (int p = 0; p < N; p++) drive(p, BASE, 1'b0, 4'hF, 32'h0, 3'd0);
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_sram_req", sram_req, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata[31:0], 0);
        req = '0;

        preload(9'd5, 32'hDEAD_BEEF);
        for (int p = 0; p < N; p++) preload(9'(10 + p), 32'hA0A0_0000 + 32'(p));
        preload(9'd511, 32'hFFFF_FFFF);
        rst = 1'b0;
        #1;
        check("idle_rvalid", rvalid, 0);

        // Single read
        drive(0, BASE + 32'd20, 1'b0, 4'hF, 32'h0, 3'd3);
        #1;
        check("rd_gnt", gnt, 4'b0001);
        check("rd_sram_req", sram_req, 1);
        check("rd_sram_addr", sram_addr, 5);
        check("rd_sram_we", sram_we, 0);
        tick();
        req = '0;
        check("rd_rvalid", rvalid, 4'b0001);
        check("rd_rdata", rdata[31:0], 32'hDEAD_BEEF);
        check("rd_rid", rid[2:0], 3);
        check("rd_err", err, 0);
        check("rd_other_rdata", rdata[63:32], 0);

        // Full contention from reset release
        rst = 1'b1;
        tick();
        for (int p = 0; p < N; p++) drive(p, BASE + 32'(4 * (10 + p)), 1'b0, 4'hF, 32'h0, 3'(p));
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k == 5) req = '0;
            #1;
            if (k < 5) check("cont_gnt", gnt, 32'(1 << (k % 4)));
            if (k > 0) begin
                pp = (k - 1) % 4;
                check("cont_rvalid", rvalid, 32'(1 << pp));
                check("cont_rdata", rdata[pp*32 +: 32], 32'hA0A0_0000 + 32'(pp));
                check("cont_rid", rid[pp*3 +: 3], 32'(pp));
            end else begin
                check("cont_rvalid0", rvalid, 0);
            end
            tick();
        end
        check("cont_drain", rvalid, 0);

        // Rotation with gaps: move pointer to 2, then ports 1 and 3 contend
        drive(1, BASE + 32'd40, 1'b0, 4'hF, 32'h0, 3'd1);
        #1;
        check("rot_setup_gnt", gnt, 4'b0010);
        tick();
        drive(3, BASE + 32'd52, 1'b0, 4'hF, 32'h0, 3'd3);
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rot_gnt", gnt, (k % 2 == 0) ? 32'h8 : 32'h2);
            check("rot_rvalid", rvalid, (k % 2 == 0) ? 32'h2 : 32'h8);
            tick();
        end
        req = '0;

        // Write then read-back of masked word
        drive(2, BASE + 32'd2044, 1'b1, 4'b0011, 32'h1234_5678, 3'd2);
        #1;
        check("wr_gnt", gnt, 4'b0100);
        check("wr_sram_req", sram_req, 1);
        check("wr_sram_we", sram_we, 1);
        check("wr_sram_addr", sram_addr, 511);
        check("wr_sram_be", sram_be, 4'b0011);
        check("wr_sram_wdata", sram_wdata, 32'h1234_5678);
        tick();
        req = '0;
        check("wr_rvalid", rvalid, 4'b0100);
        check("wr_err", err, 0);
        check("wr_rid", rid[8:6], 2);
        drive(0, BASE + 32'd2044, 1'b0, 4'hF, 32'h0, 3'd6);
        #1;
        check("rb_gnt", gnt, 4'b0001);
        tick();
        req = '0;
        check("rb_rvalid", rvalid, 4'b0001);
        check("rb_rdata", rdata[31:0], 32'hFFFF_5678);

        // Error path: just past the end, and below the base
        drive(1, BASE + 32'd2048, 1'b0, 4'hF, 32'h0, 3'd5);
        #1;
        check("err_hi_gnt", gnt, 4'b0010);
        check("err_hi_sram_req", sram_req, 0);
        check("err_hi_sram_addr", sram_addr, 0);
        tick();
        req = '0;
        check("err_hi_rvalid", rvalid, 4'b0010);
        check("err_hi_err", err, 4'b0010);
        check("err_hi_rdata", rdata[63:32], 0);
        check("err_hi_rid", rid[5:3], 5);
        drive(1, BASE - 32'd4, 1'b0, 4'hF, 32'h0, 3'd4);
        #1;
        check("err_lo_gnt", gnt, 4'b0010);
        check("err_lo_sram_req", sram_req, 0);
        tick();
        req = '0;
        check("err_lo_err", err, 4'b0010);
        check("err_lo_rdata", rdata[63:32], 0);
        drive(1, BASE + 32'd2044, 1'b0, 4'hF, 32'h0, 3'd7);
        #1;
        check("last_gnt", gnt, 4'b0010);
        check("last_sram_req", sram_req, 1);
        tick();
        req = '0;
        check("last_rvalid", rvalid, 4'b0010);
        check("last_err", err, 0);
        check("last_rdata", rdata[63:32], 32'hFFFF_5678);

        // Reset in the cycle of a grant drops the response and clears the pointer
        drive(3, BASE + 32'd20, 1'b0, 4'hF, 32'h0, 3'd1);
        #1;
        check("rstop_gnt", gnt, 4'b1000);
        rst = 1'b1;
        #1;
        check("rstop_gnt_forced", gnt, 0);
        check("rstop_sram_req", sram_req, 0);
        tick();
        req = '0;
        rst = 1'b0;
        #1;
        check("rstop_rvalid_a", rvalid, 0);
        tick();
        check("rstop_rvalid_b", rvalid, 0);
        drive(1, BASE + 32'd20, 1'b0, 4'hF, 32'h0, 3'd2);
        drive(3, BASE + 32'd20, 1'b0, 4'hF, 32'h0, 3'd3);
        #1;
        check("rstop_first_gnt", gnt, 4'b0010);
        tick();
        req = '0;
        check("rstop_rvalid", rvalid, 4'b0010);
        check("rstop_rdata", rdata[63:32], 32'hDEAD_BEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/croc_bank_arbiter.md
# croc_bank_arbiter

Round-robin arbiter that shares one single-port SRAM bank between `NumMgr` OBI requesters, e.g. core data port and DMA/user-domain traffic ahead of the crossbar's bank subordinate. It grants at most one request per cycle, drives the bank macro directly, and routes the single-cycle-latency read data back to the granted requester with its transaction ID. Out-of-range accesses are answered with an OBI error and never reach the macro.

## Interface
- `NumMgr`, 4: number of OBI requesters; must be ≥2.
- `BankNumWords`, 512: bank depth in 32-bit words; power of two.
- `BaseAddr`, 32'h1000_0000: byte address of word 0; aligned to `BankNumWords*4`.
- `IdWidth`, 3: OBI `aid`/`rid` width.
- `AW`: derived, clog2(`BankNumWords`).

- `clk_i` in 1: clock.
- `rst_i` in 1: asynchronous active-high reset.
- `req_i` in NumMgr: per-requester OBI `req`.
- `gnt_o` out NumMgr: per-requester OBI `gnt`.
- `addr_i` in NumMgr×32: byte addresses.
- `we_i` in NumMgr: write enable.
- `be_i` in NumMgr×4: byte enables.
- `wdata_i` in NumMgr×32: write data.
- `aid_i` in NumMgr×IdWidth: request IDs.
- `rvalid_o` out NumMgr: per-requester response valid.
- `rdata_o` out NumMgr×32: response data.
- `rid_o` out NumMgr×IdWidth: response IDs.
- `err_o` out NumMgr: response error.
- `sram_req_o` out 1: macro chip enable.
- `sram_we_o` out 1: macro write enable.
- `sram_addr_o` out AW: word index.
- `sram_be_o` out 4: byte enables.
- `sram_wdata_o` out 32: write data.
- `sram_rdata_i` in 32: read data, valid the cycle after `sram_req_o`.

## Operation
- Arbitration: round-robin over requesters with `req_i` high. Priority starts at pointer `rr_q`, with wrap NumMgr-1→0. Winner `w` gets `gnt_o[w]=1` in the same cycle. All other `gnt_o` are 0.
- After a grant to `w`, `rr_q` ← (w+1) mod NumMgr. The pointer is unchanged in cycles without a grant.
- Fairness: a requester holding `req_i` is granted within NumMgr cycles.
- Range check: the access is in range if `addr_i[w]-BaseAddr < BankNumWords*4`, computed as a 32-bit unsigned difference.
- In-range grant:
  - `sram_req_o=1`.
  - `sram_addr_o = (addr_i[w]-BaseAddr)[AW+1:2]`.
  - `sram_we_o`, `sram_be_o` and `sram_wdata_o` are taken from `w`.
- Out-of-range grant: `gnt_o[w]=1` but `sram_req_o=0`; the response carries `err=1` and `rdata=0`.
- Response register, loaded on every grant: `rsp_valid_q`, `rsp_idx_q`, `rsp_id_q`, `rsp_err_q`.
- Next cycle, for the requester `rsp_idx_q` only:
  - `rvalid_o=1`, `rid_o=rsp_id_q`, `err_o=rsp_err_q`.
  - `rdata_o = rsp_err_q ? 0 : sram_rdata_i`.
  - Write responses return `sram_rdata_i` unmodified, and requesters ignore it.
- Idle outputs: `rdata_o`, `rid_o` and `err_o` of non-responding ports are 0. `sram_*` outputs are 0 when `sram_req_o=0`.
- Byte lanes are not merged; `be_i` passes through to the macro.

## Timing
- Reset (async assert, sync deassert handled upstream):
  - `rr_q=0`, `rsp_valid_q=0`, all response fields 0.
  - All `gnt_o`, `rvalid_o`, `err_o` and `sram_req_o` are forced 0 while `rst_i` is high.
- Grant latency: 0 cycles (combinational from `req_i`, `addr_i`, `rr_q`).
- Response latency: exactly 1 cycle after the grant cycle, for both reads and writes.
- Throughput: 1 grant per cycle. Back-to-back grants to different requesters produce back-to-back `rvalid` on the matching ports.
- Response and grant in the same cycle on the same port is legal. OBI has no `rready` (UseRReady=0), so there is no response stall.
- Requesters must hold `req_i` and the A-channel stable until `gnt_o`. The arbiter may rotate past a requester that deasserts early.
- Reset mid-transaction drops the pending response: no `rvalid` is emitted after reset release.
- Boundary cases:
  - `addr=BaseAddr+BankNumWords*4-4` is in range.
  - `+BankNumWords*4` and `BaseAddr-4` are errors (wrap-around of the subtraction).

## Test plan
- Single read: preload word 5 = 32'hDEAD_BEEF. Port 0 reads `addr=BaseAddr+20`, `aid=3` -> `gnt_o[0]` same cycle; `sram_addr_o=5`; next cycle `rvalid_o[0]=1`, `rdata_o[0]=32'hDEAD_BEEF`, `rid_o[0]=3`, `err_o[0]=0`.
- Full contention: all 4 ports hold `req` from reset release -> grants in order 0,1,2,3,0; every port gets exactly one `rvalid` per grant, one cycle after it.
- Rotation with gaps: ports 1 and 3 request, `rr_q=2` -> grant order 3,1,3,1; never two consecutive grants to the same port while the other waits.
- Write then read: port 2 writes 32'h1234_5678 with `be=4'b0011` to word 511, over old value 32'hFFFF_FFFF -> `sram_we_o=1`, `rvalid` after 1 cycle; port 0 read returns 32'hFFFF_5678.
- Error path: port 1 accesses `BaseAddr+2048` and port 1 accesses `BaseAddr-4` -> `gnt` yes, `sram_req_o=0`, `err_o[1]=1`, `rdata_o[1]=0`; `addr=BaseAddr+2044` has no error.
- Reset mid-op: assert `rst_i` in the cycle of a grant -> no `rvalid` after release, `rr_q=0`, first post-reset grant goes to lowest requesting index.
